// File: rtl/fwd_decision_out_if.sv
// AXI4-Stream packet bundle used on both sides of fwd_decision_out.
interface fwd_decision_out_if #(
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned USER_WIDTH = 128
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tstrb;
  logic [USER_WIDTH-1:0]   tuser;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/fwd_decision_out.sv
// Joins buffered packet data with per-packet decisions, rewrites the first beat and emits it.
// FWD_DECISION_OUT_IPV4_REWRITE_EN enables MAC/TTL/checksum rewriting of forwarded first beats.
module fwd_decision_out #(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned NUM_PORTS            = 4,
  parameter int unsigned SRC_PORT_POS         = 16,
  parameter int unsigned DST_PORT_POS         = 24,
  parameter int unsigned MAC_WIDTH            = 48,
  parameter int unsigned DATA_FIFO_DEPTH_BITS = 2,
  parameter int unsigned META_FIFO_DEPTH_BITS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  fwd_decision_out_if.slave              s_axis,
  fwd_decision_out_if.master             m_axis,
  input  logic [NUM_PORTS*MAC_WIDTH-1:0] i_macs,
  input  logic                           i_meta_valid,
  output logic                           o_meta_ready,
  input  logic [1:0]                     i_meta_action,
  input  logic [7:0]                     i_meta_oport,
  input  logic [MAC_WIDTH-1:0]           i_meta_nh_mac,
  input  logic [15:0]                    i_meta_csum,
  output logic                           o_cnt_fwd,
  output logic                           o_cnt_cpu,
  output logic                           o_cnt_drop,
  output logic                           o_cnt_pass,
  output logic                           o_cnt_ttl_expired
);
  localparam int unsigned DW     = C_S_AXIS_DATA_WIDTH;
  localparam int unsigned SW     = DW / 8;
  localparam int unsigned UW     = C_S_AXIS_TUSER_WIDTH;
  localparam int unsigned DEntW  = DW + SW + UW + 1;
  localparam int unsigned MEntW  = 2 + 8 + MAC_WIDTH + 16;
  localparam int unsigned DDepth = 1 << DATA_FIFO_DEPTH_BITS;
  localparam int unsigned MDepth = 1 << META_FIFO_DEPTH_BITS;
  localparam logic [DATA_FIFO_DEPTH_BITS-1:0] DPtrOne = (DATA_FIFO_DEPTH_BITS)'(1);
  localparam logic [DATA_FIFO_DEPTH_BITS:0]   DCntOne = (DATA_FIFO_DEPTH_BITS+1)'(1);
  localparam logic [DATA_FIFO_DEPTH_BITS:0]   DCntNf  = (DATA_FIFO_DEPTH_BITS+1)'(DDepth - 1);
  localparam logic [META_FIFO_DEPTH_BITS-1:0] MPtrOne = (META_FIFO_DEPTH_BITS)'(1);
  localparam logic [META_FIFO_DEPTH_BITS:0]   MCntOne = (META_FIFO_DEPTH_BITS+1)'(1);
  localparam logic [META_FIFO_DEPTH_BITS:0]   MCntFul = (META_FIFO_DEPTH_BITS+1)'(MDepth);
  localparam logic [1:0] ActCpu = 2'd1, ActDrop = 2'd2, ActPass = 2'd3;

  typedef enum logic [1:0] {StHead, StPipe, StDrop} state_e;

  // Data FIFO (fall-through: head entry is visible combinationally)
  logic [DEntW-1:0]                dmem [DDepth];
  logic [DATA_FIFO_DEPTH_BITS-1:0] dwr_q, drd_q;
  logic [DATA_FIFO_DEPTH_BITS:0]   dcnt_q;
  logic                            d_push, d_pop, d_empty;
  logic [DW-1:0]                   h_data;
  logic [SW-1:0]                   h_strb;
  logic [UW-1:0]                   h_user;
  logic                            h_last;

  assign d_empty       = (dcnt_q == '0);
  assign s_axis.tready = !reset && (dcnt_q < DCntNf);
  assign d_push        = s_axis.tvalid && s_axis.tready;
  assign {h_last, h_strb, h_user, h_data} = dmem[drd_q];

  always_ff @(posedge clk) begin
    if (d_push) dmem[dwr_q] <= {s_axis.tlast, s_axis.tstrb, s_axis.tuser, s_axis.tdata};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwr_q  <= '0;
      drd_q  <= '0;
      dcnt_q <= '0;
    end else begin
      if (d_push) dwr_q <= dwr_q + DPtrOne;
      if (d_pop)  drd_q <= drd_q + DPtrOne;
      if (d_push && !d_pop)      dcnt_q <= dcnt_q + DCntOne;
      else if (!d_push && d_pop) dcnt_q <= dcnt_q - DCntOne;
    end
  end

  // Metadata FIFO
  logic [MEntW-1:0]                mmem [MDepth];
  logic [META_FIFO_DEPTH_BITS-1:0] mwr_q, mrd_q;
  logic [META_FIFO_DEPTH_BITS:0]   mcnt_q;
  logic                            m_push, m_pop, m_empty;
  logic [1:0]                      h_action;
  logic [7:0]                      h_oport;
  logic [MAC_WIDTH-1:0]            h_nh_mac;
  logic [15:0]                     h_csum;

  assign m_empty      = (mcnt_q == '0);
  assign o_meta_ready = !reset && (mcnt_q != MCntFul);
  assign m_push       = i_meta_valid && o_meta_ready;
  assign {h_action, h_oport, h_nh_mac, h_csum} = mmem[mrd_q];

  always_ff @(posedge clk) begin
    if (m_push) mmem[mwr_q] <= {i_meta_action, i_meta_oport, i_meta_nh_mac, i_meta_csum};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mwr_q  <= '0;
      mrd_q  <= '0;
      mcnt_q <= '0;
    end else begin
      if (m_push) mwr_q <= mwr_q + MPtrOne;
      if (m_pop)  mrd_q <= mrd_q + MPtrOne;
      if (m_push && !m_pop)      mcnt_q <= mcnt_q + MCntOne;
      else if (!m_push && m_pop) mcnt_q <= mcnt_q - MCntOne;
    end
  end

  // Decision helpers
  logic       port_found, ttl_low, decide, out_free, emit;
  logic [1:0] egress;
  logic [7:0] cpu_port;
  logic       tvalid_q, tlast_q;
  logic [DW-1:0] tdata_q, o_data;
  logic [SW-1:0] tstrb_q;
  logic [UW-1:0] tuser_q, o_user;
  state_e        state_q, state_d;

  assign ttl_low  = (h_data[79:72] <= 8'd1);
  assign cpu_port = {h_user[SRC_PORT_POS +: 7], 1'b0};
  assign out_free = !tvalid_q || m_axis.tready;
  assign decide   = (state_q == StHead) && !d_empty && !m_empty && out_free;

  always_comb begin
    port_found = 1'b0;
    egress     = '0;
    for (int unsigned n = 0; n < NUM_PORTS; n++) begin
      if (h_oport[2*n] && !port_found) begin
        port_found = 1'b1;
        egress     = 2'(n);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StHead;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StHead:  if (decide && !h_last) state_d = (h_action == ActDrop) ? StDrop : StPipe;
      StPipe:  if (!d_empty && out_free && h_last) state_d = StHead;
      StDrop:  if (!d_empty && h_last) state_d = StHead;
      default: state_d = StHead;
    endcase
  end

  always_comb begin
    d_pop             = 1'b0;
    m_pop             = 1'b0;
    emit              = 1'b0;
    o_data            = h_data;
    o_user            = h_user;
    o_cnt_fwd         = 1'b0;
    o_cnt_cpu         = 1'b0;
    o_cnt_drop        = 1'b0;
    o_cnt_pass        = 1'b0;
    o_cnt_ttl_expired = 1'b0;
    unique case (state_q)
      StHead: begin
        if (decide) begin
          d_pop = 1'b1;
          m_pop = 1'b1;
          unique case (h_action)
            ActPass: begin
              emit       = 1'b1;
              o_cnt_pass = 1'b1;
            end
            ActDrop: o_cnt_drop = 1'b1;
            ActCpu: begin
              emit                        = 1'b1;
              o_cnt_cpu                   = 1'b1;
              o_user[DST_PORT_POS +: 8]   = cpu_port;
            end
            default: begin
              emit = 1'b1;
              // Expiring TTL or no usable egress port: punt to the CPU instead.
              if (ttl_low || !port_found) begin
                o_user[DST_PORT_POS +: 8] = cpu_port;
                o_cnt_ttl_expired         = ttl_low;
                o_cnt_cpu                 = !ttl_low;
              end else begin
                o_user[DST_PORT_POS +: 8] = h_oport;
                o_cnt_fwd                 = 1'b1;
`ifdef FWD_DECISION_OUT_IPV4_REWRITE_EN
                o_data[DW-1 -: MAC_WIDTH]           = h_nh_mac;
                o_data[DW-MAC_WIDTH-1 -: MAC_WIDTH] = i_macs[egress*MAC_WIDTH +: MAC_WIDTH];
                o_data[79:72]                       = h_data[79:72] - 8'd1;
                o_data[63:48]                       = h_csum;
`endif
              end
            end
          endcase
        end
      end
      StPipe: begin
        if (!d_empty && out_free) begin
          d_pop = 1'b1;
          emit  = 1'b1;
        end
      end
      StDrop: d_pop = !d_empty;
      default: ;
    endcase
  end

`ifndef FWD_DECISION_OUT_IPV4_REWRITE_EN
  logic unused_rewrite;
  assign unused_rewrite = ^{h_nh_mac, h_csum, egress, i_macs};
`endif

  // Single output register stage; holds while the sink stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tuser_q  <= '0;
      tlast_q  <= 1'b0;
    end else if (out_free) begin
      tvalid_q <= emit;
      if (emit) begin
        tdata_q <= o_data;
        tstrb_q <= h_strb;
        tuser_q <= o_user;
        tlast_q <= h_last;
      end
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = tdata_q;
  assign m_axis.tstrb  = tstrb_q;
  assign m_axis.tuser  = tuser_q;
  assign m_axis.tlast  = tlast_q;
endmodule

// File: tb/tb_fwd_decision_out.sv
// Directed, table-driven bench for fwd_decision_out plus back-to-back and reset sequences.
module tb_fwd_decision_out;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int NP = 4;
  localparam int CFwd = 0, CCpu = 1, CDrop = 2, CPass = 3, CTtl = 4;
  localparam int NVec = 11;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  strb;
    logic [127:0] user;
    logic         last;
  } beat_t;

  typedef struct {
    string      name;
    logic [1:0] action;
    logic [7:0] oport;
    logic [7:0] ttl;
    logic [7:0] src;
    int         beats;
    int         delay;
    bit         rnd;
    bit         emit;
    logic [7:0] dst;
    bit         rw;
    int         eg;
    int         cnt;
  } vec_t;

  logic clk, reset;
  fwd_decision_out_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) s_if ();
  fwd_decision_out_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();
  logic [NP*48-1:0] macs;
  logic meta_valid, meta_ready;
  logic [1:0] meta_action;
  logic [7:0] meta_oport;
  logic [47:0] meta_nh;
  logic [15:0] meta_csum;
  logic c_fwd, c_cpu, c_drop, c_pass, c_ttl;

  fwd_decision_out dut (
    .clk(clk), .reset(reset), .s_axis(s_if), .m_axis(m_if), .i_macs(macs),
    .i_meta_valid(meta_valid), .o_meta_ready(meta_ready), .i_meta_action(meta_action),
    .i_meta_oport(meta_oport), .i_meta_nh_mac(meta_nh), .i_meta_csum(meta_csum),
    .o_cnt_fwd(c_fwd), .o_cnt_cpu(c_cpu), .o_cnt_drop(c_drop), .o_cnt_pass(c_pass),
    .o_cnt_ttl_expired(c_ttl)
  );

  int n_cmp = 0, n_fail = 0, cyc = 0;
  int cnt_seen[5];
  beat_t out_q[$];
  int out_cyc[$];
  beat_t cur, prev_beat;
  bit prev_stall = 0, rnd_ready = 0;
  vec_t vecs[NVec];

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk);
      #1 m_if.tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Output monitor: collects accepted beats, checks stall stability, tallies pulses.
  always @(negedge clk) begin
    cur = {m_if.tdata, m_if.tstrb, m_if.tuser, m_if.tlast};
    if (reset) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        n_cmp++;
        if (cur !== prev_beat || m_if.tvalid !== 1'b1) begin
          n_fail++;
          $display("FAIL stall_hold: got %0h expected %0h", cur, prev_beat);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        out_q.push_back(cur);
        out_cyc.push_back(cyc);
      end
      cnt_seen[CFwd]  += int'(c_fwd);
      cnt_seen[CCpu]  += int'(c_cpu);
      cnt_seen[CDrop] += int'(c_drop);
      cnt_seen[CPass] += int'(c_pass);
      cnt_seen[CTtl]  += int'(c_ttl);
      prev_stall = m_if.tvalid && !m_if.tready;
      prev_beat  = cur;
    end
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic beat_t mk_beat(int pid, int b, int nb, logic [7:0] ttl, logic [7:0] src);
    beat_t r;
    for (int w = 0; w < 8; w++) r.data[w*32 +: 32] = {8'(pid), 8'(b), 8'(w), 8'h5A};
    if (b == 0) r.data[79:72] = ttl;
    r.user          = '0;
    r.user[127:96]  = {8'(pid), 24'hC0FFEE};
    r.user[15:0]    = 16'(nb * 32);
    r.user[23:16]   = src;
    r.user[31:24]   = 8'hEE;
    r.last          = (b == nb - 1);
    r.strb          = r.last ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    return r;
  endfunction

  task automatic send_beat(input beat_t b);
    int g = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = b.data;
    s_if.tstrb  = b.strb;
    s_if.tuser  = b.user;
    s_if.tlast  = b.last;
    @(negedge clk);
    while (!s_if.tready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL s_tready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 s_if.tvalid = 1'b0;
  endtask

  task automatic send_meta(input logic [1:0] a, input logic [7:0] op, input logic [47:0] nh,
                           input logic [15:0] cs);
    int g = 0;
    meta_valid  = 1'b1;
    meta_action = a;
    meta_oport  = op;
    meta_nh     = nh;
    meta_csum   = cs;
    @(negedge clk);
    while (!meta_ready && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) begin
      n_cmp++;
      n_fail++;
      $display("FAIL meta_ready_timeout: got 0 expected 1");
    end
    @(posedge clk);
    #1 meta_valid = 1'b0;
  endtask

  task automatic clear_obs();
    out_q.delete();
    out_cyc.delete();
    foreach (cnt_seen[i]) cnt_seen[i] = 0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (out_q.size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, input int pid);
    beat_t inb[$];
    beat_t e;
    int nexp, tot;
    logic [47:0] nh;
    logic [15:0] cs;
    nh = {40'hAABBCCDDEE, 8'(pid)};
    cs = {8'hC5, 8'(pid)};
    for (int b = 0; b < v.beats; b++) inb.push_back(mk_beat(pid, b, v.beats, v.ttl, v.src));
    @(posedge clk);
    #1;
    clear_obs();
    rnd_ready = v.rnd;
    fork
      begin
        foreach (inb[b]) send_beat(inb[b]);
      end
      begin
        repeat (v.delay) @(posedge clk);
        if (v.delay > 0) begin
          #1 chk({v.name, "_no_early_out"}, 256'(out_q.size()) + 256'(m_if.tvalid), '0);
        end
        send_meta(v.action, v.oport, nh, cs);
      end
    join
    nexp = v.emit ? v.beats : 0;
    wait_out(nexp);
    rnd_ready = 0;
    chk({v.name, "_beats"}, 256'(out_q.size()), 256'(nexp));
    for (int b = 0; b < nexp && b < out_q.size(); b++) begin
      e = inb[b];
      if (b == 0) begin
        e.user[31:24] = v.dst;
`ifdef FWD_DECISION_OUT_IPV4_REWRITE_EN
        if (v.rw) begin
          e.data[255:208] = nh;
          e.data[207:160] = macs[v.eg*48 +: 48];
          e.data[79:72]   = v.ttl - 8'd1;
          e.data[63:48]   = cs;
        end
`endif
      end
      chk($sformatf("%s_b%0d_data", v.name, b), out_q[b].data, e.data);
      chk($sformatf("%s_b%0d_user", v.name, b), 256'(out_q[b].user), 256'(e.user));
      chk($sformatf("%s_b%0d_strb_last", v.name, b), 256'({out_q[b].strb, out_q[b].last}),
          256'({e.strb, e.last}));
    end
    tot = 0;
    foreach (cnt_seen[i]) tot += cnt_seen[i];
    chk({v.name, "_cnt_hit"}, 256'(cnt_seen[v.cnt]), 256'(1));
    chk({v.name, "_cnt_total"}, 256'(tot), 256'(1));
  endtask

  initial begin
    beat_t ina[$], inbb[$];
    for (int n = 0; n < NP; n++) macs[n*48 +: 48] = 48'h0200_5E00_1000 + 48'(n * 17);
    vecs[0]  = '{"fwd_basic", 2'd0, 8'h04, 8'd64, 8'h01, 3, 0, 1'b0, 1'b1, 8'h04, 1'b1, 1, CFwd};
    vecs[1]  = '{"ttl_one", 2'd0, 8'h04, 8'd1, 8'h10, 2, 0, 1'b0, 1'b1, 8'h20, 1'b0, 0, CTtl};
    vecs[2]  = '{"ttl_zero", 2'd0, 8'h01, 8'd0, 8'h02, 1, 0, 1'b0, 1'b1, 8'h04, 1'b0, 0, CTtl};
    vecs[3]  = '{"drop4", 2'd2, 8'h00, 8'd64, 8'h01, 4, 0, 1'b0, 1'b0, 8'hEE, 1'b0, 0, CDrop};
    vecs[4]  = '{"pass1", 2'd3, 8'h00, 8'd64, 8'h08, 1, 0, 1'b0, 1'b1, 8'hEE, 1'b0, 0, CPass};
    vecs[5]  = '{"cpu", 2'd1, 8'h00, 8'd64, 8'h84, 2, 0, 1'b0, 1'b1, 8'h08, 1'b0, 0, CCpu};
    vecs[6]  = '{"no_port", 2'd0, 8'h02, 8'd64, 8'h04, 2, 0, 1'b0, 1'b1, 8'h08, 1'b0, 0, CCpu};
    vecs[7]  = '{"fwd_stall", 2'd0, 8'h50, 8'd10, 8'h03, 5, 0, 1'b1, 1'b1, 8'h50, 1'b1, 2, CFwd};
    vecs[8]  = '{"meta_late", 2'd0, 8'h01, 8'd200, 8'h05, 4, 5, 1'b0, 1'b1, 8'h01, 1'b1, 0, CFwd};
    vecs[9]  = '{"fwd_port3", 2'd0, 8'h40, 8'd2, 8'h06, 1, 0, 1'b0, 1'b1, 8'h40, 1'b1, 3, CFwd};
    vecs[10] = '{"drop1", 2'd2, 8'h04, 8'd0, 8'h01, 1, 0, 1'b0, 1'b0, 8'hEE, 1'b0, 0, CDrop};

    reset = 1'b1;
    s_if.tvalid = 0; s_if.tdata = '0; s_if.tstrb = '0; s_if.tuser = '0; s_if.tlast = 0;
    meta_valid = 0; meta_action = '0; meta_oport = '0; meta_nh = '0; meta_csum = '0;
    repeat (3) @(negedge clk);
    chk("rst_tvalid", 256'(m_if.tvalid), '0);
    chk("rst_s_tready", 256'(s_if.tready), '0);
    chk("rst_meta_ready", 256'(meta_ready), '0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_s_tready", 256'(s_if.tready), 256'(1));
    chk("idle_meta_ready", 256'(meta_ready), 256'(1));

    for (int i = 0; i < NVec; i++) run_vec(vecs[i], i + 1);

    // Back-to-back: PASS (2 beats) then CPU (3 beats) with decisions queued ahead.
    for (int b = 0; b < 2; b++) ina.push_back(mk_beat(20, b, 2, 8'd64, 8'h01));
    for (int b = 0; b < 3; b++) inbb.push_back(mk_beat(21, b, 3, 8'd64, 8'h03));
    @(posedge clk);
    #1;
    clear_obs();
    send_meta(2'd3, 8'h00, 48'h0, 16'h0);
    send_meta(2'd1, 8'h00, 48'h0, 16'h0);
    foreach (ina[b]) send_beat(ina[b]);
    foreach (inbb[b]) send_beat(inbb[b]);
    wait_out(5);
    chk("b2b_beats", 256'(out_q.size()), 256'(5));
    for (int i = 1; i < 5 && i < out_cyc.size(); i++)
      chk($sformatf("b2b_gap%0d", i), 256'(out_cyc[i] - out_cyc[i-1]), 256'(1));
    if (out_q.size() >= 3) begin
      chk("b2b_a0_user", 256'(out_q[0].user), 256'(ina[0].user));
      chk("b2b_b0_dst", 256'(out_q[2].user[31:24]), 256'(8'h06));
    end
    chk("b2b_cnt_pass", 256'(cnt_seen[CPass]), 256'(1));
    chk("b2b_cnt_cpu", 256'(cnt_seen[CCpu]), 256'(1));

    // Reset in the middle of a 4-beat packet.
    ina.delete();
    for (int b = 0; b < 4; b++) ina.push_back(mk_beat(25, b, 4, 8'd64, 8'h01));
    @(posedge clk);
    #1;
    clear_obs();
    fork
      send_meta(2'd0, 8'h01, 48'h1, 16'h1);
      send_beat(ina[0]);
    join
    send_beat(ina[1]);
    chk("rst_mid_pre_tvalid", 256'(m_if.tvalid), 256'(1));
    #2 reset = 1'b1;
    #1;
    chk("rst_mid_tvalid", 256'(m_if.tvalid), '0);
    chk("rst_mid_tdata", m_if.tdata, '0);
    chk("rst_mid_tuser_strb_last", 256'({m_if.tuser, m_if.tstrb, m_if.tlast}), '0);
    chk("rst_mid_readies", 256'({s_if.tready, meta_ready}), '0);
    chk("rst_mid_pulses", 256'({c_fwd, c_cpu, c_drop, c_pass, c_ttl}), '0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    run_vec(vecs[0], 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
